rc_req_tracker: RTL
===================

# rc_req_tracker

Tracks outstanding core memory requests in an ENTRIES-deep buffer on the request-issue side of the ring controller. It allocates a free entry per accepted request, issues pending entries to the fabric strictly oldest-first, holds read entries until their response returns, then frees them and returns read data to the core. It produces the allocate/deallocate and oldest-select behaviour from the issuing end.

## Interface
- ENTRIES, 4, buffer depth (power of two, 2..16)
- ADDR_W, 32, request address width
- DATA_W, 32, data width
- ID_W, $clog2(ENTRIES), derived entry-id width (not overridable)

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- ReqValid  in  1  core request valid
- ReqReady  out  1  request accepted when ReqValid && ReqReady
- ReqOpcode  in  1  0 = RD, 1 = WR
- ReqAddress  in  ADDR_W  request address
- ReqData  in  DATA_W  write data (ignored for RD)
- IssueValid  out  1  oldest pending entry presented to fabric
- IssueReady  in  1  fabric takes issue
- IssueOpcode / IssueAddress / IssueData  out  1 / ADDR_W / DATA_W  payload of issued entry
- IssueId  out  ID_W  entry index, echoed by fabric in RspId
- RspValid  in  1  read response valid
- RspId  in  ID_W  entry the response belongs to
- RspData  in  DATA_W  read data
- RetValid  out  1  read data to core, one-cycle pulse
- RetId / RetData  out  ID_W / DATA_W  returned entry and data
- Occupancy  out  ID_W+1  number of non-FREE entries
- ErrRsp  out  1  sticky: response hit an entry not in WAIT

## Operation
- Per-entry state: FREE, PEND, WAIT.
- Accept: lowest-index FREE entry -> PEND, payload stored, age assigned youngest.
- Age invariant: age[i] = number of valid entries allocated after entry i; oldest valid entry has the highest age. Ages of valid entries are always unique and < ENTRIES.
- Issue select: PEND entry with highest age; IssueValid = any PEND.
- Issue handshake: RD entry PEND -> WAIT; WR entry PEND -> FREE (posted).
- Response: RspValid with entry RspId in WAIT -> FREE, RetValid/RetId/RetData next cycle. Entry not in WAIT: state unchanged, no RetValid, ErrRsp set until reset.
- Simultaneous accept, WR issue-free and response-free in one cycle: all applied; ages updated so invariant holds next cycle.
- Full (no FREE): ReqReady = 0. Empty: IssueValid = 0, Occupancy = 0.

## Timing
- Reset values: all entries FREE, all ages 0, IssueValid 0, RetValid 0, Occupancy 0, ErrRsp 0, payload outputs 0; ReqReady 0 while Rst high, 1 from first cycle after.
- ReqReady and Issue* driven only from registered state; entries freed in cycle t are allocatable at t+1 (no same-cycle reuse).
- Accept at t -> entry visible PEND and IssueValid high earliest t+1.
- IssueValid/IssueId/payload stable until handshake; IssueId cannot change while IssueValid && !IssueReady.
- RspValid at t -> RetValid at t+1; no backpressure on Ret*.
- Reset asserted mid-operation: all in-flight entries dropped immediately; late responses after reset set ErrRsp.

## Structure
- Package rc_req_tracker_pkg: opcode enum (RD/WR), entry state enum (FREE/PEND/WAIT), entry payload struct.
- Sub-module rc_age_tracker: per-entry age counters, inputs alloc one-hot, free vector, pending mask; outputs one-hot oldest-pending. Top holds state, payload array, free-entry find-first, handshakes.

## Test plan
- Reset then 4 RD accepts (addr 0x10,0x20,0x30,0x40), IssueReady=1 -> issues in order ids 0,1,2,3; ReqReady 0 after 4th accept; Occupancy 4.
- Responses out of order (ids 2,0,3,1, data 0xA..0xD) -> RetValid each next cycle with matching id/data; Occupancy reaches 0.
- Fill 4, respond id 1, accept new request -> it takes id 1, is issued after all older pending entries.
- WR accept with IssueReady held 0 for 5 cycles -> IssueId/payload stable; on IssueReady entry frees, Occupancy decrements next cycle, no RetValid.
- Same cycle: accept, WR issue, response to WAIT entry -> all three applied; age order of remaining entries checked against model.
- RspValid for FREE entry -> ErrRsp 1 and held; Rst mid-traffic -> all outputs to reset values, ReqReady 1 after release.

Source files
------------

// File: rtl/rc_req_tracker_pkg.sv
// Shared types for the ring-controller request tracker: opcodes, entry states
// and the stored request payload.
package rc_req_tracker_pkg;

   localparam int RC_ADDR_W = 32;
   localparam int RC_DATA_W = 32;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_PEND = 2'd1,
      ST_WAIT = 2'd2
   } entry_state_e;

   typedef struct packed {
      opcode_e               opcode;
      logic [RC_ADDR_W-1:0]  addr;
      logic [RC_DATA_W-1:0]  data;
   } entry_payload_t;

endpackage

// File: rtl/rc_age_tracker.sv
// Per-entry age counters: age = number of live entries allocated later, so the
// oldest pending entry is the pending one with the highest age.
module rc_age_tracker #(
   parameter int ENTRIES = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [ENTRIES-1:0] i_alloc,
   input  logic [ENTRIES-1:0] i_free,
   input  logic [ENTRIES-1:0] i_pend,
   output logic [ENTRIES-1:0] o_oldest
);

   localparam int ID_W = $clog2(ENTRIES);

   logic [ID_W-1:0]    r_age [ENTRIES];
   logic [ENTRIES-1:0] r_valid;
   logic [ID_W-1:0]    w_dec [ENTRIES];
   logic [ID_W-1:0]    w_inc;

   assign w_inc = (|i_alloc) ? ID_W'(1) : '0;

   // Each survivor drops one step for every younger entry freed this cycle.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         w_dec[i] = '0;
         for (int j = 0; j < ENTRIES; j++) begin
            if (i_free[j] && (r_age[j] < r_age[i])) w_dec[i] = w_dec[i] + ID_W'(1);
         end
      end
   end

   always_comb begin
      o_oldest = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         o_oldest[i] = i_pend[i];
         for (int j = 0; j < ENTRIES; j++) begin
            if ((j != i) && i_pend[j] && (r_age[j] > r_age[i])) o_oldest[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (i_alloc[i]) begin
               r_valid[i] <= 1'b1;
               r_age[i]   <= '0;
            end else if (i_free[i]) begin
               r_valid[i] <= 1'b0;
               r_age[i]   <= '0;
            end else if (r_valid[i]) begin
               r_age[i] <= r_age[i] - w_dec[i] + w_inc;
            end
         end
      end
   end

endmodule

// File: rtl/rc_req_tracker.sv
// Outstanding-request buffer: allocates lowest free entry, issues oldest pending
// entry, retires reads on response and returns their data to the core.
module rc_req_tracker
   import rc_req_tracker_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int ADDR_W  = RC_ADDR_W,
   parameter int DATA_W  = RC_DATA_W
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       ReqValid,
   output logic                       ReqReady,
   input  logic                       ReqOpcode,
   input  logic [ADDR_W-1:0]          ReqAddress,
   input  logic [DATA_W-1:0]          ReqData,
   output logic                       IssueValid,
   input  logic                       IssueReady,
   output logic                       IssueOpcode,
   output logic [ADDR_W-1:0]          IssueAddress,
   output logic [DATA_W-1:0]          IssueData,
   output logic [$clog2(ENTRIES)-1:0] IssueId,
   input  logic                       RspValid,
   input  logic [$clog2(ENTRIES)-1:0] RspId,
   input  logic [DATA_W-1:0]          RspData,
   output logic                       RetValid,
   output logic [$clog2(ENTRIES)-1:0] RetId,
   output logic [DATA_W-1:0]          RetData,
   output logic [$clog2(ENTRIES):0]   Occupancy,
   output logic                       ErrRsp
);

   localparam int ID_W = $clog2(ENTRIES);

   entry_state_e   r_state [ENTRIES];
   entry_payload_t r_pl    [ENTRIES];
   logic              r_ready_en;
   logic              r_ret_vld;
   logic [ID_W-1:0]   r_ret_id;
   logic [DATA_W-1:0] r_ret_data;
   logic              r_err;

   logic [ENTRIES-1:0] w_free_mask;
   logic [ENTRIES-1:0] w_pend_mask;
   logic [ID_W:0]      w_occ;
   logic [ID_W-1:0]    w_alloc_idx;
   logic               w_accept;
   logic [ENTRIES-1:0] w_alloc_oh;
   logic [ENTRIES-1:0] w_oldest;
   logic [ID_W-1:0]    w_iss_idx;
   entry_payload_t     w_iss_pl;
   logic               w_iss_fire;
   logic               w_iss_wr;
   logic [ENTRIES-1:0] w_iss_oh;
   logic               w_rsp_hit;
   logic [ENTRIES-1:0] w_rsp_oh;
   logic [ENTRIES-1:0] w_age_free;

   always_comb begin
      w_occ       = '0;
      w_free_mask = '0;
      w_pend_mask = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         w_free_mask[i] = (r_state[i] == ST_FREE);
         w_pend_mask[i] = (r_state[i] == ST_PEND);
         if (r_state[i] != ST_FREE) w_occ = w_occ + (ID_W+1)'(1);
      end
   end

   // Scanning downward leaves the lowest free index as the winner.
   always_comb begin
      w_alloc_idx = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (w_free_mask[i]) w_alloc_idx = ID_W'(i);
      end
   end

   always_comb begin
      w_iss_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (w_oldest[i]) w_iss_idx = ID_W'(i);
      end
   end

   assign ReqReady   = r_ready_en & (|w_free_mask);
   assign w_accept   = ReqValid & ReqReady;
   assign w_alloc_oh = w_accept ? (ENTRIES'(1) << w_alloc_idx) : '0;

   assign w_iss_pl   = r_pl[w_iss_idx];
   assign IssueValid = |w_pend_mask;
   assign w_iss_fire = IssueValid & IssueReady;
   assign w_iss_wr   = (w_iss_pl.opcode == OP_WR);
   assign w_iss_oh   = w_iss_fire ? w_oldest : '0;

   assign w_rsp_hit  = RspValid && (r_state[RspId] == ST_WAIT);
   assign w_rsp_oh   = w_rsp_hit ? (ENTRIES'(1) << RspId) : '0;
   assign w_age_free = w_rsp_oh | (w_iss_wr ? w_iss_oh : '0);

   rc_age_tracker #(.ENTRIES(ENTRIES)) u_age (
      .i_clk    (Clk),
      .i_rst    (Rst),
      .i_alloc  (w_alloc_oh),
      .i_free   (w_age_free),
      .i_pend   (w_pend_mask),
      .o_oldest (w_oldest)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < ENTRIES; i++) r_state[i] <= ST_FREE;
         r_ready_en <= 1'b0;
         r_ret_vld  <= 1'b0;
         r_ret_id   <= '0;
         r_ret_data <= '0;
         r_err      <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_alloc_oh[i])    r_state[i] <= ST_PEND;
            else if (w_iss_oh[i]) r_state[i] <= w_iss_wr ? ST_FREE : ST_WAIT;
            else if (w_rsp_oh[i]) r_state[i] <= ST_FREE;
         end
         r_ret_vld <= w_rsp_hit;
         if (w_rsp_hit) begin
            r_ret_id   <= RspId;
            r_ret_data <= RspData;
         end
         if (RspValid && !w_rsp_hit) r_err <= 1'b1;
      end
   end

   // Payload needs no reset: it is only visible through a PEND entry.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (w_alloc_oh[i]) begin
            r_pl[i] <= '{opcode: opcode_e'(ReqOpcode),
                         addr:   ReqAddress,
                         data:   ReqOpcode ? ReqData : '0};
         end
      end
   end

   assign IssueId      = w_iss_idx;
   assign IssueOpcode  = IssueValid & w_iss_wr;
   assign IssueAddress = IssueValid ? w_iss_pl.addr : '0;
   assign IssueData    = IssueValid ? w_iss_pl.data : '0;
   assign RetValid     = r_ret_vld;
   assign RetId        = r_ret_id;
   assign RetData      = r_ret_data;
   assign Occupancy    = w_occ;
   assign ErrRsp       = r_err;

endmodule
